rotary_operand_ctrl: RTL and testbench

Consumes the rotation_event / rotation_direction pair produced by the rotary-encoder decoder.
Turns each detent into a +1/-1 step on one of two WIDTH-bit operands (A, B). A debounced select button chooses which operand is edited, or locks both.
Operands feed the downstream adder/subtractor and the LED display.

---
 rtl/rotary_ctrl_pkg.sv | 13 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/rotary_operand_ctrl.sv | 106 ++++++++++
 tb/tb_rotary_operand_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_ctrl_pkg.sv
// Shared types and constants for the rotary operand controller.
package rotary_ctrl_pkg;

    typedef enum logic [1:0] {
        EDIT_A = 2'b00,
        EDIT_B = 2'b01,
        HOLD   = 2'b10
    } edit_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: a level change on the raw input is accepted only after
// it has been held for DEBOUNCE_CYCLES consecutive clocks; an accepted rising
// edge produces a one-cycle press pulse.
module btn_debounce
    import rotary_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count how long the raw input has disagreed with the accepted level; flip once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= raw;
                press <= raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotary_operand_ctrl.sv
// Rotary operand controller: turns encoder detents into +1/-1 steps on operand A
// or B, with a debounced select button cycling EDIT_A -> EDIT_B -> HOLD.
// Optional macro SATURATE_EN: steps clamp at 0 and 2^WIDTH-1 instead of wrapping.
module rotary_operand_ctrl
    import rotary_ctrl_pkg::*;
#(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rotation_event,
    input  logic             rotation_direction,
    input  logic             sel_btn,
    input  logic             clr,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       edit_sel,
    output logic             step_pulse
);

    edit_state_t      state_q, state_d;
    logic             ev_q;
    logic             rot_edge;
    logic             btn_level;
    logic             btn_press;
    logic             btn_adv;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] stepped;
    logic             clamp;
    logic             step_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sel_btn),
        .level(btn_level),
        .press(btn_press)
    );

    assign rot_edge = rotation_event & ~ev_q;
    // A press only ever coincides with a freshly accepted high level; qualifying on both keeps the FSM tied to the debounced state.
    assign btn_adv  = btn_press & btn_level;

    // Cycle through the edit modes on each accepted button press.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EDIT_A:  if (btn_adv) state_d = EDIT_B;
            EDIT_B:  if (btn_adv) state_d = HOLD;
            HOLD:    if (btn_adv) state_d = EDIT_A;
            default: state_d = EDIT_A;
        endcase
    end

    // Compute the next operand values; clear wins over a rotation step, and HOLD ignores rotation.
    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        step_d  = 1'b0;
        target  = (state_q == EDIT_A) ? op_a_q : op_b_q;
        stepped = (rotation_direction == DIR_INC) ? target + WIDTH'(1) : target - WIDTH'(1);
`ifdef SATURATE_EN
        clamp   = (rotation_direction == DIR_INC) ? (target == '1) : (target == '0);
`else
        clamp   = 1'b0;
`endif
        if (clr) begin
            op_a_d = '0;
            op_b_d = '0;
        end else if (rot_edge && (state_q != HOLD) && !clamp) begin
            step_d = 1'b1;
            if (state_q == EDIT_A) begin
                op_a_d = stepped;
            end else begin
                op_b_d = stepped;
            end
        end
    end

    // Register the edge detector, mode, operands and step pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_q       <= 1'b0;
            state_q    <= EDIT_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            step_pulse <= 1'b0;
        end else begin
            ev_q       <= rotation_event;
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            step_pulse <= step_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign edit_sel = state_q;

endmodule

// File: tb/tb_rotary_operand_ctrl.sv
// Self-checking bench for rotary_operand_ctrl (WIDTH=7, DEBOUNCE_CYCLES=4).
// Steps are scoreboarded: expected operand values are queued when a detent is
// driven and compared when the DUT raises step_pulse. Honours SATURATE_EN.
module tb_rotary_operand_ctrl;

    localparam int W = 7;

    typedef struct {
        bit         isB;
        logic [W-1:0] value;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rotation_event;
    logic         rotation_direction;
    logic         sel_btn;
    logic         clr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   edit_sel;
    logic         step_pulse;

    sb_entry_t    sbQ[$];
    logic [W-1:0] expA, expB;
    logic [1:0]   expSel;
    int           checks = 0;
    int           errors = 0;

    rotary_operand_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rotation_event    (rotation_event),
        .rotation_direction(rotation_direction),
        .sel_btn           (sel_btn),
        .clr               (clr),
        .op_a              (op_a),
        .op_b              (op_b),
        .edit_sel          (edit_sel),
        .step_pulse        (step_pulse)
    );

    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive all control inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic ev, input logic dir, input logic btn, input logic clrIn);
        rotation_event     = ev;
        rotation_direction = dir;
        sel_btn            = btn;
        clr                = clrIn;
        @(posedge clk);
        #1;
    endtask

    // Reference step behaviour: wrap by default, clamp when saturation is built in.
    task automatic stepModel(input logic [W-1:0] v, input logic dir, output logic [W-1:0] nv, output bit moved);
        moved = 1'b1;
        nv    = dir ? v + 7'd1 : v - 7'd1;
`ifdef SATURATE_EN
        if ((dir && v == 7'd127) || (!dir && v == 7'd0)) begin
            moved = 1'b0;
            nv    = v;
        end
`endif
    endtask

    function automatic logic [1:0] nextSel(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Scoreboard consumer: every step pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && step_pulse === 1'b1) begin
            checkOutput("step_expected", int'(sbQ.size() != 0), 1);
            if (sbQ.size() != 0) begin
                sb_entry_t e;
                e = sbQ.pop_front();
                if (e.isB) checkOutput("sb_op_b", op_b, e.value);
                else       checkOutput("sb_op_a", op_a, e.value);
            end
        end
    end

    // One detent: event high for one cycle, check pulse latency and width.
    task automatic rotStep(input logic dir);
        logic [W-1:0] cur, nv;
        bit           moved;
        cur = (expSel == 2'b00) ? expA : expB;
        stepModel(cur, dir, nv, moved);
        if (expSel == 2'b10) moved = 1'b0;
        if (moved) begin
            if (expSel == 2'b00) expA = nv;
            else                 expB = nv;
            sbQ.push_back('{isB: (expSel == 2'b01), value: nv});
        end
        applyStimulus(1'b1, dir, 1'b0, 1'b0);
        checkOutput("step_latency", step_pulse, int'(moved));
        applyStimulus(1'b0, dir, 1'b0, 1'b0);
        checkOutput("step_width", step_pulse, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Clean press and release, long enough for the debouncer both ways.
    task automatic pressButton();
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expSel = nextSel(expSel);
        checkOutput("edit_sel_press", edit_sel, expSel);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("edit_sel_release", edit_sel, expSel);
    endtask

    initial begin
        rst_n = 1'b0;
        expA = '0; expB = '0; expSel = 2'b00;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_op_a", op_a, 0);
        checkOutput("reset_op_b", op_b, 0);
        checkOutput("reset_edit_sel", edit_sel, 0);
        checkOutput("reset_step", step_pulse, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] three increments on A");
        repeat (3) rotStep(1'b1);
        checkOutput("t1_op_a", op_a, 3);
        checkOutput("t1_op_b", op_b, 0);

        $display("[TB] wrap/saturate boundaries");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expA = '0; expB = '0;
        checkOutput("clr_op_a", op_a, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rotStep(1'b0);
        checkOutput("t2_dec_from_0", op_a, expA);
        while (expA != 7'd127) rotStep(1'b1);
        rotStep(1'b1);
        checkOutput("t2_inc_from_127", op_a, expA);

        $display("[TB] bouncing select button");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expA = '0; expB = '0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bounce_only", edit_sel, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expSel = 2'b01;
        checkOutput("debounced_press", edit_sel, expSel);

        $display("[TB] mode cycling and HOLD");
        pressButton();
        repeat (5) rotStep(1'b1);
        checkOutput("hold_op_a", op_a, expA);
        checkOutput("hold_op_b", op_b, expB);
        pressButton();
        pressButton();
        pressButton();
        pressButton();

        $display("[TB] press coincident with rotation, clr coincident with rotation");
        rotStep(1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expA = expA + 7'd1;
        sbQ.push_back('{isB: 1'b0, value: expA});
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        expSel = 2'b01;
        checkOutput("coinc_edit_sel", edit_sel, expSel);
        checkOutput("coinc_step", step_pulse, 1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rotStep(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        expA = '0; expB = '0;
        checkOutput("clr_rot_op_a", op_a, 0);
        checkOutput("clr_rot_op_b", op_b, 0);
        checkOutput("clr_rot_step", step_pulse, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] held event and reset mid-sequence");
        expB = expB + 7'd1;
        sbQ.push_back('{isB: 1'b1, value: expB});
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("held_first_step", step_pulse, 1);
        repeat (9) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_op_b", op_b, 1);
        repeat (8) rotStep(1'b1);
        pressButton();
        pressButton();
        repeat (5) rotStep(1'b1);
        pressButton();
        pressButton();
        checkOutput("pre_reset_op_a", op_a, 5);
        checkOutput("pre_reset_op_b", op_b, 9);
        checkOutput("pre_reset_sel", edit_sel, 2);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expA = '0; expB = '0; expSel = 2'b00;
        checkOutput("mid_reset_op_a", op_a, 0);
        checkOutput("mid_reset_op_b", op_b, 0);
        checkOutput("mid_reset_sel", edit_sel, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rotStep(1'b1);
        checkOutput("post_reset_op_a", op_a, 1);

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_drained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
